// File: rtl/ls_unit.sv
// ls_unit: load/store execution unit; byte-serial access over the shared memory port.
// Optional LS_ALIGN_CHECK_EN: misaligned H/W ops complete with no memory cycle and pulse LSmisalign.
`ifndef TagBus
`define TagBus 4
`endif
`ifndef NameBus
`define NameBus 5
`endif
`ifndef OpBus
`define OpBus 4
`endif
`ifndef tagFree
`define tagFree 0
`endif
`ifndef nameFree
`define nameFree 0
`endif
`ifndef NOP
`define NOP 0
`endif
`ifndef LB
`define LB 1
`endif
`ifndef LH
`define LH 2
`endif
`ifndef LW
`define LW 3
`endif
`ifndef LBU
`define LBU 4
`endif
`ifndef LHU
`define LHU 5
`endif
`ifndef SB
`define SB 6
`endif
`ifndef SH
`define SH 7
`endif
`ifndef SW
`define SW 8
`endif

module ls_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = `TagBus,
  parameter int unsigned NAME_W = `NameBus,
  parameter int unsigned OP_W   = `OpBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LSworkEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [TAG_W-1:0]  wrtTag,
  input  logic [NAME_W-1:0] wrtName,
  input  logic [OP_W-1:0]   opCode,
  output logic              LSreadEn,
  output logic              memReq,
  input  logic              memGrant,
  output logic [31:0]       memAddr,
  output logic              memWr,
  output logic [7:0]        memDout,
  input  logic [7:0]        memDin,
  output logic              enLSwrt,
  output logic [TAG_W-1:0]  LStag,
  output logic [DATA_W-1:0] LSdata,
  output logic [NAME_W-1:0] LSname
`ifdef LS_ALIGN_CHECK_EN
  ,
  output logic              LSmisalign
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_q;
  logic [NAME_W-1:0] name_q;
  logic [OP_W-1:0]   op_q;
  logic [31:0]       st_q, ld_q, ld_ext_c;
  logic [ADDR_W-1:0] addr_q, addr_c;
  logic [IDX_W-1:0]  idx_q, cnt_q, cnt_c;
  logic [1:0]        lane_c;
  logic              rd_pend_q, accept_c, last_c, skip_c;
`ifdef LS_ALIGN_CHECK_EN
  logic              mis_q;
`endif

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_W'(`LB)) || (op == OP_W'(`LH)) || (op == OP_W'(`LW)) ||
           (op == OP_W'(`LBU)) || (op == OP_W'(`LHU));
  endfunction

  // Byte count per opcode; zero marks NOP or an unknown opcode that is not accepted.
  always_comb begin
    cnt_c = '0;
    if (opCode == OP_W'(`LB) || opCode == OP_W'(`LBU) || opCode == OP_W'(`SB))
      cnt_c = IDX_W'(1);
    else if (opCode == OP_W'(`LH) || opCode == OP_W'(`LHU) || opCode == OP_W'(`SH))
      cnt_c = IDX_W'(2);
    else if (opCode == OP_W'(`LW) || opCode == OP_W'(`SW))
      cnt_c = IDX_W'(4);
  end

  assign addr_c   = ADDR_W'(operandO + imm);
  assign accept_c = (state == IDLE) && LSworkEn && (cnt_c != '0);
  assign last_c   = (IDX_W'(idx_q + 1'b1) == cnt_q);
  assign lane_c   = 2'(idx_q - 1'b1);
`ifdef LS_ALIGN_CHECK_EN
  assign skip_c   = ((cnt_c == IDX_W'(2)) && addr_c[0]) ||
                    ((cnt_c == IDX_W'(4)) && (addr_c[1:0] != 2'b00));
`else
  assign skip_c   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept_c) state_nxt = skip_c ? DONE : ACCESS;
      ACCESS: if (memGrant && last_c) state_nxt = is_load(op_q) ? DRAIN : DONE;
      DRAIN:  state_nxt = DONE;
      DONE:   state_nxt = IDLE;
    endcase
  end

  // Operation latch, byte index, and load assembly from the byte returned one cycle after a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= TAG_W'(`tagFree);
      name_q    <= NAME_W'(`nameFree);
      op_q      <= OP_W'(`NOP);
      st_q      <= '0;
      ld_q      <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
`ifdef LS_ALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      rd_pend_q <= (state == ACCESS) && memGrant && is_load(op_q);
      if (accept_c) begin
        tag_q  <= wrtTag;
        name_q <= wrtName;
        op_q   <= opCode;
        st_q   <= 32'(operandT);
        addr_q <= addr_c;
        cnt_q  <= cnt_c;
        idx_q  <= '0;
        ld_q   <= '0;
`ifdef LS_ALIGN_CHECK_EN
        mis_q  <= skip_c;
`endif
      end else begin
        if ((state == ACCESS) && memGrant) idx_q <= IDX_W'(idx_q + 1'b1);
        if (rd_pend_q) ld_q[{lane_c, 3'b000} +: 8] <= memDin;
      end
    end
  end

  always_comb begin
    ld_ext_c = ld_q;
    if (op_q == OP_W'(`LB))       ld_ext_c = {{24{ld_q[7]}}, ld_q[7:0]};
    else if (op_q == OP_W'(`LH))  ld_ext_c = {{16{ld_q[15]}}, ld_q[15:0]};
    else if (op_q == OP_W'(`LBU)) ld_ext_c = {24'h0, ld_q[7:0]};
    else if (op_q == OP_W'(`LHU)) ld_ext_c = {16'h0, ld_q[15:0]};
  end

  always_comb begin
    LSreadEn = (state == IDLE) && !LSworkEn;
    memReq   = 1'b0;
    memWr    = 1'b0;
    memAddr  = '0;
    memDout  = '0;
    enLSwrt  = 1'b0;
    LStag    = TAG_W'(`tagFree);
    LSdata   = '0;
    LSname   = NAME_W'(`nameFree);
`ifdef LS_ALIGN_CHECK_EN
    LSmisalign = 1'b0;
`endif
    case (state)
      ACCESS: begin
        memReq  = 1'b1;
        memAddr = addr_q + ADDR_W'(idx_q);
        memWr   = !is_load(op_q);
        if (!is_load(op_q)) memDout = st_q[{idx_q[1:0], 3'b000} +: 8];
      end
      DONE: begin
        if (is_load(op_q) && (tag_q != TAG_W'(`tagFree))) begin
          enLSwrt = 1'b1;
          LStag   = tag_q;
          LSdata  = DATA_W'(ld_ext_c);
          LSname  = name_q;
        end
`ifdef LS_ALIGN_CHECK_EN
        LSmisalign = mis_q;
`endif
      end
      default: ;
    endcase
  end

endmodule
